mem_arbiter: RTL and testbench

Two-requester arbiter and address decoder for the core's single shared memory port. It grants either the instruction-fetch requester or the data (load/store) requester, holds one transaction outstanding at a time, and steers it to BRAM, UART, CLINT, CLIC or AXI using the shared address map. Addresses outside every window are answered locally with an access error and are never forwarded. It sits between the fetch/LSU stages and the peripheral interconnect.

---
 rtl/mem_arbiter_pkg.sv | 41 ++++
 rtl/mem_decode.sv | 24 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and interconnect blocks.
//   - Address map: <dev>_base_addr (inclusive) / <dev>_top_addr (exclusive).
//   - mem_sel_t: 5-bit one-hot device select, indexed by the Sel* constants.
//   - arb_state_e: arbiter FSM states.
//   - in_window(): unsigned base <= addr < top test.
package mem_arbiter_pkg;

  localparam logic [31:0] bram_base_addr  = 32'h0000_0000;
  localparam logic [31:0] bram_top_addr   = 32'h0000_1000;
  localparam logic [31:0] uart_base_addr  = 32'h0100_0000;
  localparam logic [31:0] uart_top_addr   = 32'h0100_1000;
  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr  = 32'h0201_0000;
  localparam logic [31:0] clic_base_addr  = 32'h0300_0000;
  localparam logic [31:0] clic_top_addr   = 32'h0301_0000;
  localparam logic [31:0] axi_base_addr   = 32'h8000_0000;
  localparam logic [31:0] axi_top_addr    = 32'hC000_0000;

  typedef logic [4:0] mem_sel_t;

  localparam int unsigned SelBram  = 0;
  localparam int unsigned SelUart  = 1;
  localparam int unsigned SelClint = 2;
  localparam int unsigned SelClic  = 3;
  localparam int unsigned SelAxi   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StErrI,
    StErrD
  } arb_state_e;

  // Offset form gives a single unsigned compare and stays correct for a zero base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] top);
    return (addr - base) < (top - base);
  endfunction

endpackage

// File: rtl/mem_decode.sv
// Combinational address decoder for the shared memory map.
//   addr_i : byte address
//   sel_o  : one-hot device select (bram, uart, clint, clic, axi)
//   hit_o  : address falls inside some window
module mem_decode
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic [4:0]  sel_o,
  output logic        hit_o
);

  always_comb begin
    sel_o           = '0;
    sel_o[SelBram]  = in_window(addr_i, bram_base_addr, bram_top_addr);
    sel_o[SelUart]  = in_window(addr_i, uart_base_addr, uart_top_addr);
    sel_o[SelClint] = in_window(addr_i, clint_base_addr, clint_top_addr);
    sel_o[SelClic]  = in_window(addr_i, clic_base_addr, clic_top_addr);
    sel_o[SelAxi]   = in_window(addr_i, axi_base_addr, axi_top_addr);
  end

  assign hit_o = |sel_o;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and address decoder for the core's shared memory port.
//   clock, reset           : rising-edge clock, async active-low reset
//   imem_* / dmem_*        : fetch and load/store requester handshakes
//   mem_valid .. mem_wstrb : registered request to the peripheral interconnect
//   mem_rdata, mem_ready   : slave response
// One transaction is outstanding at a time; unmapped addresses are answered
// locally with an error and never reach the shared port.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,

  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,

  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [4:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  arb_state_e  state_q;
  logic        last_data_q;  // 1: data requester was granted most recently
  logic        grant_i;
  logic        grant_d;
  logic [31:0] req_addr;
  logic [4:0]  dec_sel;
  logic        dec_hit;

  // Round-robin only matters under contention; a lone requester always wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (imem_valid && dmem_valid) begin
        grant_i = last_data_q;
        grant_d = !last_data_q;
      end else begin
        grant_i = imem_valid;
        grant_d = dmem_valid;
      end
    end
  end

  assign req_addr = grant_i ? imem_addr : dmem_addr;

  mem_decode u_decode (
    .addr_i (req_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_data_q <= 1'b1;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_sel     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_i || grant_d) begin
            last_data_q <= grant_d;
            if (dec_hit) begin
              mem_valid <= 1'b1;
              mem_instr <= grant_i;
              mem_sel   <= dec_sel;
              mem_addr  <= req_addr;
              // Fetches are reads; never forward stale store data with them.
              mem_wdata <= grant_i ? 32'h0 : dmem_wdata;
              mem_wstrb <= grant_i ? 4'h0 : dmem_wstrb;
              state_q   <= grant_i ? StBusyI : StBusyD;
            end else begin
              state_q   <= grant_i ? StErrI : StErrD;
            end
          end
        end
        StBusyI, StBusyD: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StErrI, StErrD: state_q <= StIdle;
        default:        state_q <= StIdle;
      endcase
    end
  end

  // Responses: pass-through from the slave while busy, local error otherwise.
  always_comb begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    imem_error = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    dmem_error = 1'b0;
    unique case (state_q)
      StBusyI: begin
        imem_ready = mem_ready;
        imem_rdata = mem_ready ? mem_rdata : 32'h0;
      end
      StBusyD: begin
        dmem_ready = mem_ready;
        dmem_rdata = mem_ready ? mem_rdata : 32'h0;
      end
      StErrI: begin
        imem_ready = 1'b1;
        imem_error = 1'b1;
      end
      StErrD: begin
        dmem_ready = 1'b1;
        dmem_error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic        mem_valid;
  logic        mem_instr;
  logic [4:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_error (imem_error),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_error (dmem_error),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave: answers after slave_delay wait cycles ----------------
  int          slave_delay = 0;
  int          wait_cnt;
  logic [31:0] slave_data = 32'h0;
  logic        stray = 1'b0;

  assign mem_ready = stray | (mem_valid && (wait_cnt == slave_delay));
  assign mem_rdata = slave_data;

  always @(posedge clock or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- reference model ----------------
  // Window index by address, or -1 when unmapped.
  function automatic int win_idx(input logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if (a >= 32'h0100_0000 && a < 32'h0100_1000) return 1;
    if (a >= 32'h0200_0000 && a < 32'h0201_0000) return 2;
    if (a >= 32'h0300_0000 && a < 32'h0301_0000) return 3;
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return 4;
    return -1;
  endfunction

  // Who gets the port this cycle: 0 nobody, 1 fetch, 2 data.
  function automatic int pick(input int owner, input logic iv, input logic dv, input bit last_d);
    if (owner != 0) return 0;
    if (iv && dv) return last_d ? 1 : 2;
    if (iv) return 1;
    if (dv) return 2;
    return 0;
  endfunction

  int          m_owner;  // 0 none, 1 fetch, 2 data
  bit          m_err;
  bit          m_last_d;
  logic        m_valid;
  logic        m_instr;
  logic [4:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  int          m_who;
  int          m_idx;

  assign m_who = pick(m_owner, imem_valid, dmem_valid, m_last_d);
  assign m_idx = win_idx(m_who == 1 ? imem_addr : dmem_addr);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_owner  <= 0;
      m_err    <= 1'b0;
      m_last_d <= 1'b1;
      m_valid  <= 1'b0;
      m_instr  <= 1'b0;
      m_sel    <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else if (m_owner != 0) begin
      if (m_err || mem_ready) begin
        m_owner <= 0;
        m_err   <= 1'b0;
        m_valid <= 1'b0;
      end
    end else if (m_who != 0) begin
      m_owner  <= m_who;
      m_last_d <= (m_who == 2);
      if (m_idx < 0) begin
        m_err <= 1'b1;
      end else begin
        m_valid <= 1'b1;
        m_instr <= (m_who == 1);
        m_sel   <= 5'(1 << m_idx);
        m_addr  <= (m_who == 1) ? imem_addr : dmem_addr;
        m_wdata <= dmem_wdata;
        m_wstrb <= dmem_wstrb;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  logic        e_i_rdy;
  logic        e_d_rdy;
  logic [31:0] e_i_rd;
  logic [31:0] e_d_rd;

  always @(negedge clock) begin
    e_i_rdy = (m_owner == 1) && (m_err || mem_ready);
    e_d_rdy = (m_owner == 2) && (m_err || mem_ready);
    e_i_rd  = (m_owner == 1 && !m_err && mem_ready) ? mem_rdata : 32'h0;
    e_d_rd  = (m_owner == 2 && !m_err && mem_ready) ? mem_rdata : 32'h0;
    check("imem_ready", imem_ready, e_i_rdy);
    check("imem_error", imem_error, (m_owner == 1) && m_err);
    check("imem_rdata", imem_rdata, e_i_rd);
    check("dmem_ready", dmem_ready, e_d_rdy);
    check("dmem_error", dmem_error, (m_owner == 2) && m_err);
    check("dmem_rdata", dmem_rdata, e_d_rd);
    check("mem_valid", mem_valid, m_valid);
    if (m_valid) begin
      check("mem_instr", mem_instr, m_instr);
      check("mem_sel", mem_sel, m_sel);
      check("mem_addr", mem_addr, m_addr);
      if (!m_instr) begin
        check("mem_wdata", mem_wdata, m_wdata);
        check("mem_wstrb", mem_wstrb, m_wstrb);
      end
    end
  end

  int d_ready_cnt = 0;
  always @(negedge clock) if (dmem_ready) d_ready_cnt <= d_ready_cnt + 1;

  // ---------------- requester tasks (call at posedge+1) ----------------
  task automatic do_i(input logic [31:0] a, output int lat, output logic [4:0] sel,
                      output int done_cyc);
    int n;
    bit seen;
    imem_addr  = a;
    imem_valid = 1'b1;
    n = 0; seen = 1'b0; lat = -1; sel = '0; done_cyc = -1;
    while (!seen && n < 60) begin
      @(negedge clock);
      if (imem_ready) begin
        seen = 1'b1; lat = n; sel = mem_sel; done_cyc = cyc;
      end
      n++;
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL i_timeout: got no imem_ready expected one within 60 cycles");
    end
    @(posedge clock);
    #1 imem_valid = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output int lat, output logic [4:0] sel, output logic [3:0] wsv,
                      output int done_cyc);
    int n;
    bit seen;
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_wstrb = ws;
    dmem_valid = 1'b1;
    n = 0; seen = 1'b0; lat = -1; sel = '0; wsv = '0; done_cyc = -1;
    while (!seen && n < 60) begin
      @(negedge clock);
      if (dmem_ready) begin
        seen = 1'b1; lat = n; sel = mem_sel; wsv = mem_wstrb; done_cyc = cyc;
      end
      n++;
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL d_timeout: got no dmem_ready expected one within 60 cycles");
    end
    @(posedge clock);
    #1 dmem_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int          li, ld, ci, cd, r0;
    logic [4:0]  si, sd;
    logic [3:0]  wsd;

    reset = 1'b0;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_sel", mem_sel, 5'b0);
    check("rst_imem_ready", imem_ready, 1'b0);
    check("rst_dmem_ready", dmem_ready, 1'b0);

    // Single fetch, zero-wait slave
    apply_reset();
    slave_delay = 0;
    slave_data  = 32'hDEAD_BEEF;
    imem_addr   = 32'h0000_0010;
    imem_valid  = 1'b1;
    @(negedge clock);
    check("fetch_c0_mem_valid", mem_valid, 1'b0);
    @(negedge clock);
    check("fetch_mem_valid", mem_valid, 1'b1);
    check("fetch_mem_sel", mem_sel, 5'b00001);
    check("fetch_mem_instr", mem_instr, 1'b1);
    check("fetch_imem_ready", imem_ready, 1'b1);
    check("fetch_imem_rdata", imem_rdata, 32'hDEAD_BEEF);
    check("fetch_imem_error", imem_error, 1'b0);
    @(posedge clock);
    #1 imem_valid = 1'b0;

    // Contention from reset: fetch first, then store to UART, then fetch again
    apply_reset();
    slave_data = 32'h0BAD_F00D;
    fork
      do_i(32'h0000_0000, li, si, ci);
      do_d(32'h0100_0000, 32'hCAFE_F00D, 4'hF, ld, sd, wsd, cd);
    join
    check("rr1_i_first", ci < cd, 1'b1);
    check("rr1_i_lat", li, 1);
    check("rr1_d_lat", ld, 3);
    check("rr1_d_sel", sd, 5'b00010);
    check("rr1_d_wstrb", wsd, 4'hF);
    fork
      do_i(32'h0000_0004, li, si, ci);
      do_d(32'h0100_0004, 32'h1111_2222, 4'h1, ld, sd, wsd, cd);
    join
    check("rr3_i_first", ci < cd, 1'b1);
    check("rr3_d_lat", ld, 3);

    // Unmapped: one byte past BRAM, with a stray mem_ready during the error cycle
    slave_data = 32'h5A5A_5A5A;
    dmem_addr  = 32'h0000_1000;
    dmem_wstrb = 4'h0;
    dmem_valid = 1'b1;
    @(negedge clock);
    check("unmap_c0_ready", dmem_ready, 1'b0);
    check("unmap_c0_mem_valid", mem_valid, 1'b0);
    @(posedge clock);
    #1 stray = 1'b1;
    @(negedge clock);
    check("unmap_ready", dmem_ready, 1'b1);
    check("unmap_error", dmem_error, 1'b1);
    check("unmap_rdata", dmem_rdata, 32'h0);
    check("unmap_mem_valid", mem_valid, 1'b0);
    @(posedge clock);
    #1 begin stray = 1'b0; dmem_valid = 1'b0; end
    // Stray mem_ready while idle
    @(posedge clock);
    #1 stray = 1'b1;
    @(posedge clock);
    #1 stray = 1'b0;

    // Last BRAM word
    do_d(32'h0000_0FFC, 32'h0, 4'h0, ld, sd, wsd, cd);
    check("bram_edge_sel", sd, 5'b00001);
    check("bram_edge_lat", ld, 1);

    // AXI with five wait states
    slave_delay = 5;
    slave_data  = 32'h7777_8888;
    r0 = d_ready_cnt;
    do_d(32'h8000_0000, 32'h1234_5678, 4'h3, ld, sd, wsd, cd);
    repeat (3) @(posedge clock);
    check("axi_lat", ld, 6);
    check("axi_sel", sd, 5'b10000);
    check("axi_one_ready", d_ready_cnt - r0, 1);

    // Reset in the middle of a data transaction, fetch to CLINT pending
    slave_delay = 20;
    @(posedge clock);
    #1 begin dmem_addr = 32'h8000_0010; dmem_wstrb = 4'h0; dmem_valid = 1'b1; end
    repeat (3) @(posedge clock);
    #1 begin imem_addr = 32'h0200_0004; imem_valid = 1'b1; end
    @(negedge clock);
    check("mid_busy_mem_valid", mem_valid, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_mem_valid", mem_valid, 1'b0);
    check("mid_rst_mem_sel", mem_sel, 5'b0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_dmem_ready", dmem_ready, 1'b0);
    check("mid_rst_imem_ready", imem_ready, 1'b0);
    dmem_valid  = 1'b0;
    slave_delay = 0;
    @(posedge clock);
    #1 reset = 1'b1;
    do_i(32'h0200_0004, li, si, ci);
    check("post_rst_i_sel", si, 5'b00100);
    check("post_rst_i_lat", li, 1);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
